// File: rtl/color_cmd_scheduler.sv
// Two-requester round-robin command scheduler for a downstream Color/HSV state machine.
// Issues a command for HOLD_CYCLES cycles, waits one settle cycle, then pulses done with the latched result.
module color_cmd_scheduler #(
  parameter int         HOLD_CYCLES = 1,
  parameter logic [1:0] IDLE_CODE   = 2'h3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_cmd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_cmd,
  output logic       req1_ready,
  output logic [1:0] fsm_in,
  input  logic [1:0] fsm_out,
  output logic       busy,
  output logic       grant_id,
  output logic       done,
  output logic [1:0] done_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] result_q, result_d;
  logic       sel;
  logic       accept;

  // Tie goes to the requester that was not granted last; a lone requester always wins.
  always_comb begin
    sel    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept = (state_q == S_IDLE) && (req0_valid || req1_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ISSUE;
      S_ISSUE:  if (cnt_q == 4'd0) state_d = S_SETTLE;
      S_SETTLE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = rst_n && (state_q == S_IDLE) && req0_valid && !sel;
    req1_ready  = rst_n && (state_q == S_IDLE) && req1_valid && sel;
    fsm_in      = (state_q == S_ISSUE) ? cmd_q : IDLE_CODE;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    grant_id    = grant_q;
    done_result = result_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    grant_d  = grant_q;
    last_d   = last_q;
    result_d = result_q;
    if (accept) begin
      cnt_d   = 4'(HOLD_CYCLES - 1);
      cmd_d   = sel ? req1_cmd : req0_cmd;
      grant_d = sel;
      last_d  = sel;
    end
    if (state_q == S_ISSUE && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (state_q == S_SETTLE) begin
      result_d = fsm_out;
    end
  end

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      cmd_q    <= 2'd0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= 2'd0;
    end else begin
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_color_cmd_scheduler.sv
// Directed bench: two scheduler instances (HOLD_CYCLES 1 and 2), each driving a Color/HSV model.
module tb_color_cmd_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a0v, a1v, b0v, b1v;
  logic [1:0] a0c, a1c, b0c, b1c;
  logic       a0r, a1r, b0r, b1r;
  logic [1:0] a_fin, a_fout, a_res, b_fin, b_fout, b_res;
  logic       a_busy, a_gid, a_done, b_busy, b_gid, b_done;

  color_cmd_scheduler #(.HOLD_CYCLES(1), .IDLE_CODE(2'h3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a0v), .req0_cmd(a0c), .req0_ready(a0r),
    .req1_valid(a1v), .req1_cmd(a1c), .req1_ready(a1r),
    .fsm_in(a_fin), .fsm_out(a_fout), .busy(a_busy), .grant_id(a_gid),
    .done(a_done), .done_result(a_res)
  );

  color_cmd_scheduler #(.HOLD_CYCLES(2), .IDLE_CODE(2'h3)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b0v), .req0_cmd(b0c), .req0_ready(b0r),
    .req1_valid(b1v), .req1_cmd(b1c), .req1_ready(b1r),
    .fsm_in(b_fin), .fsm_out(b_fout), .busy(b_busy), .grant_id(b_gid),
    .done(b_done), .done_result(b_res)
  );

  // Downstream model: 0=Red(out 2), 1=Blue(out 1), 2=HSV_idle(out 2).
  // in 0 -> Red, in 1 toggles Red/Blue, in 2 -> HSV_idle, in 3 holds.
  function automatic logic [1:0] ds_next(input logic [1:0] st, input logic [1:0] in);
    logic [1:0] nx;
    nx = st;
    case (in)
      2'd0: nx = 2'd0;
      2'd1: nx = (st == 2'd0) ? 2'd1 : 2'd0;
      2'd2: nx = 2'd2;
      default: nx = st;
    endcase
    return nx;
  endfunction

  logic [1:0] m1_q, m2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_q <= 2'd0;
      m2_q <= 2'd0;
    end else begin
      m1_q <= ds_next(m1_q, a_fin);
      m2_q <= ds_next(m2_q, b_fin);
    end
  end
  assign a_fout = (m1_q == 2'd1) ? 2'd1 : 2'd2;
  assign b_fout = (m2_q == 2'd1) ? 2'd1 : 2'd2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a0v = 1'b1; a1v = 1'b0; b0v = 1'b0; b1v = 1'b0;
    a0c = 2'd0; a1c = 2'd0; b0c = 2'd0; b1c = 2'd0;
    #1;
    check_eq("rst_fsm_in", 8'(a_fin), 8'h3);
    check_eq("rst_busy", 8'(a_busy), 8'h0);
    check_eq("rst_done", 8'(a_done), 8'h0);
    check_eq("rst_result", 8'(a_res), 8'h0);
    check_eq("rst_grant", 8'(a_gid), 8'h0);
    check_eq("rst_ready0", 8'(a0r), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a0v = 1'b0;

    // HOLD 1, Red, cmd 1 -> Blue
    @(negedge clk); a0v = 1'b1; a0c = 2'd1; #1;
    check_eq("t1_ready0", 8'(a0r), 8'h1);
    check_eq("t1_ready1", 8'(a1r), 8'h0);
    @(negedge clk); a0v = 1'b0; a0c = 2'd2; #1;
    check_eq("t1_issue_fsm_in", 8'(a_fin), 8'h1);
    check_eq("t1_issue_busy", 8'(a_busy), 8'h1);
    check_eq("t1_issue_grant", 8'(a_gid), 8'h0);
    @(negedge clk); #1;
    check_eq("t1_settle_fsm_in", 8'(a_fin), 8'h3);
    check_eq("t1_settle_done", 8'(a_done), 8'h0);
    @(negedge clk); #1;
    check_eq("t1_done", 8'(a_done), 8'h1);
    check_eq("t1_result", 8'(a_res), 8'h1);
    check_eq("t1_done_fsm_in", 8'(a_fin), 8'h3);
    @(negedge clk); #1;
    check_eq("t1_after_done", 8'(a_done), 8'h0);
    check_eq("t1_after_busy", 8'(a_busy), 8'h0);
    check_eq("t1_result_hold", 8'(a_res), 8'h1);

    // req1 cmd 2 then req0 cmd 0, from Red
    pulse_reset();
    @(negedge clk); a1v = 1'b1; a1c = 2'd2; #1;
    check_eq("t2_ready1", 8'(a1r), 8'h1);
    check_eq("t2_ready0", 8'(a0r), 8'h0);
    @(negedge clk); a1v = 1'b0; #1;
    check_eq("t2_grant1", 8'(a_gid), 8'h1);
    check_eq("t2_fsm_in2", 8'(a_fin), 8'h2);
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("t2_done_a", 8'(a_done), 8'h1);
    check_eq("t2_result_a", 8'(a_res), 8'h2);
    @(negedge clk); a0v = 1'b1; a0c = 2'd0; #1;
    check_eq("t2_grant_hold", 8'(a_gid), 8'h1);
    check_eq("t2_ready0", 8'(a0r), 8'h1);
    @(negedge clk); a0v = 1'b0; #1;
    check_eq("t2_grant0", 8'(a_gid), 8'h0);
    check_eq("t2_fsm_in0", 8'(a_fin), 8'h0);
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("t2_done_b", 8'(a_done), 8'h1);
    check_eq("t2_result_b", 8'(a_res), 8'h2);

    // both valid continuously: alternating grants, HOLD+3 = 4 cycles apart
    pulse_reset();
    @(negedge clk); a0v = 1'b1; a1v = 1'b1; a0c = 2'd3; a1c = 2'd3;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq($sformatf("rr_ready0_k%0d", k), 8'(a0r), 8'((k % 4 == 0) && ((k / 4) % 2 == 0)));
      check_eq($sformatf("rr_ready1_k%0d", k), 8'(a1r), 8'((k % 4 == 0) && ((k / 4) % 2 == 1)));
      if (k % 4 == 1) check_eq($sformatf("rr_grant_k%0d", k), 8'(a_gid), 8'((k / 4) % 2));
    end
    a0v = 1'b0; a1v = 1'b0;
    repeat (2) @(negedge clk);

    // reset in first ISSUE cycle, after a req0 grant
    @(negedge clk); a0v = 1'b1; a0c = 2'd1; #1;
    check_eq("t4_ready0", 8'(a0r), 8'h1);
    @(negedge clk); rst_n = 1'b0; #1;
    check_eq("t4_fsm_in", 8'(a_fin), 8'h3);
    check_eq("t4_busy", 8'(a_busy), 8'h0);
    check_eq("t4_ready0_rst", 8'(a0r), 8'h0);
    check_eq("t4_done_rst", 8'(a_done), 8'h0);
    @(negedge clk); rst_n = 1'b1; a0v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("t4_no_done_%0d", k), 8'(a_done), 8'h0);
    end
    @(negedge clk); a0v = 1'b1; a1v = 1'b1; #1;
    check_eq("t4_tie_ready0", 8'(a0r), 8'h1);
    check_eq("t4_tie_ready1", 8'(a1r), 8'h0);
    @(negedge clk); a0v = 1'b0; a1v = 1'b0;

    // HOLD 2, Red, cmd 1 -> toggles twice back to Red
    @(negedge clk); b0v = 1'b1; b0c = 2'd1; #1;
    check_eq("t5_ready0", 8'(b0r), 8'h1);
    @(negedge clk); b0v = 1'b0; #1;
    check_eq("t5_fsm_in_c1", 8'(b_fin), 8'h1);
    @(negedge clk); #1;
    check_eq("t5_fsm_in_c2", 8'(b_fin), 8'h1);
    check_eq("t5_busy", 8'(b_busy), 8'h1);
    @(negedge clk); #1;
    check_eq("t5_settle_fsm_in", 8'(b_fin), 8'h3);
    check_eq("t5_settle_done", 8'(b_done), 8'h0);
    @(negedge clk); #1;
    check_eq("t5_done", 8'(b_done), 8'h1);
    check_eq("t5_result", 8'(b_res), 8'h2);

    // cmd changes during ISSUE are ignored
    @(negedge clk); b0v = 1'b1; b0c = 2'd2; #1;
    check_eq("t6_ready0", 8'(b0r), 8'h1);
    @(negedge clk); b0c = 2'd0; #1;
    check_eq("t6_fsm_in_c1", 8'(b_fin), 8'h2);
    check_eq("t6_ready_busy", 8'(b0r), 8'h0);
    @(negedge clk); b0c = 2'd1; #1;
    check_eq("t6_fsm_in_c2", 8'(b_fin), 8'h2);
    @(negedge clk); b0v = 1'b0; #1;
    check_eq("t6_settle_fsm_in", 8'(b_fin), 8'h3);
    @(negedge clk); #1;
    check_eq("t6_done", 8'(b_done), 8'h1);
    check_eq("t6_result", 8'(b_res), 8'h2);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
